quant_coeff_sequencer: RTL

Sequences loading of the quantizer coefficient BRAM from PPC-written software registers. The quant0 address register supplies the start address, count and go toggle; a second register supplies the fill value. Writes always go to the shadow bank of a double-buffered coefficient RAM. The live bank swaps only on a datapath sync pulse, so the quantizer never sees a half-written table. Status is returned to the PPC through a simulink2ppc register.

---
 rtl/quant_coeff_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/quant_coeff_sequencer.sv
// rtl/quant_coeff_sequencer.sv - double-buffered quantizer coefficient RAM loader
// Optional ramp fill (per-word step from data_reg[31:16]) built only with QUANT_SEQ_RAMP_EN.
module quant_coeff_sequencer #(
  parameter int ADDR_W = 10,
  parameter int COEF_W = 16
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic [31:0]       addr_reg,
  input  logic [31:0]       data_reg,
  input  logic              sync_in,
  output logic              bram_we,
  output logic [ADDR_W:0]   bram_addr,
  output logic [COEF_W-1:0] bram_din,
  output logic              active_bank,
  output logic [31:0]       status_out
);

  typedef enum logic [1:0] {S_PRIME, S_IDLE, S_FILL, S_ARM} state_t;

  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  state_t            r_state;
  logic              r_go_q;
  logic              r_swap;
  logic              r_overrun;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_left;
  logic [7:0]        r_done_cnt;

  logic              w_go_edge;
  logic [ADDR_W:0]   w_cnt_raw;
  logic [ADDR_W:0]   w_cnt;
  logic [ADDR_W-1:0] w_start;
  logic [COEF_W-1:0] w_value;
  logic [COEF_W-1:0] w_din_next;
  logic              w_unused;

  assign w_go_edge = addr_reg[31] ^ r_go_q;
  assign w_cnt_raw = addr_reg[16+ADDR_W:16];
  assign w_cnt     = (w_cnt_raw > CNT_MAX) ? CNT_MAX : w_cnt_raw;
  assign w_start   = addr_reg[ADDR_W-1:0];
  assign w_value   = data_reg[COEF_W-1:0];
  assign w_unused  = ^{addr_reg, data_reg};

`ifdef QUANT_SEQ_RAMP_EN
  logic [COEF_W-1:0] r_step;

  // Accumulate the step onto the previous word instead of multiplying by the index.
  assign w_din_next = bram_din + r_step;

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      r_step <= '0;
    end else if (r_state == S_IDLE && w_go_edge) begin
      r_step <= data_reg[COEF_W+15:16];
    end
  end
`else
  assign w_din_next = bram_din;
`endif

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      r_state     <= S_PRIME;
      r_go_q      <= 1'b0;
      r_swap      <= 1'b0;
      r_overrun   <= 1'b0;
      r_addr      <= '0;
      r_left      <= '0;
      r_done_cnt  <= 8'd0;
      bram_we     <= 1'b0;
      bram_addr   <= '0;
      bram_din    <= '0;
      active_bank <= 1'b0;
      status_out  <= 32'd0;
    end else begin
      // PRIME absorbs a go bit left set across reset without triggering.
      r_go_q     <= addr_reg[31];
      status_out <= {16'h0000, r_done_cnt, 4'h0, r_overrun, active_bank,
                     r_state == S_ARM, (r_state == S_FILL) || (r_state == S_ARM)};
      case (r_state)
        S_PRIME: begin
          bram_we <= 1'b0;
          r_state <= S_IDLE;
        end
        S_IDLE: begin
          bram_we <= 1'b0;
          if (w_go_edge) begin
            r_swap <= addr_reg[30];
            if (w_cnt != '0) begin
              bram_we   <= 1'b1;
              bram_addr <= {~active_bank, w_start};
              bram_din  <= w_value;
              r_addr    <= w_start + ADDR_W'(1);
              r_left    <= w_cnt - CNT_ONE;
              if (w_cnt == CNT_ONE) begin
                r_done_cnt <= r_done_cnt + 8'd1;
                r_state    <= addr_reg[30] ? S_ARM : S_IDLE;
              end else begin
                r_state <= S_FILL;
              end
            end else if (addr_reg[30]) begin
              r_state <= S_ARM;
            end else begin
              r_done_cnt <= r_done_cnt + 8'd1;
            end
          end
        end
        S_FILL: begin
          if (w_go_edge) begin
            r_overrun <= 1'b1;
          end
          bram_we   <= 1'b1;
          bram_addr <= {~active_bank, r_addr};
          bram_din  <= w_din_next;
          r_addr    <= r_addr + ADDR_W'(1);
          r_left    <= r_left - CNT_ONE;
          if (r_left == CNT_ONE) begin
            r_done_cnt <= r_done_cnt + 8'd1;
            r_state    <= r_swap ? S_ARM : S_IDLE;
          end
        end
        S_ARM: begin
          bram_we <= 1'b0;
          if (w_go_edge) begin
            r_overrun <= 1'b1;
          end
          if (sync_in) begin
            active_bank <= ~active_bank;
            r_done_cnt  <= r_done_cnt + 8'd1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          bram_we <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
